mem_boot_responder: RTL and testbench

Memory responder for the pipelined CPU: a word-addressed store with two registered read ports and one write port, driven by the CPU's fetch and load/store stages. After reset it first fills itself from a byte-serial boot stream and asserts `ready` when the image is in place. The CPU is held in reset until `ready` is high.

---
 rtl/mem_boot_responder.sv | 127 ++++++++++++
 tb/tb_mem_boot_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_responder.sv
// Dual-read, single-write 16-bit word store that loads itself from a byte-serial boot stream before serving the CPU.
// Optional write-first read bypass: define MEM_BYPASS_EN (read-first when undefined).
module mem_boot_responder #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [15:0]       rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [15:0]       rdata1,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic              boot_valid,
  input  logic [7:0]        boot_byte,
  output logic              boot_ready,
  output logic              ready,
  output logic [ADDR_W:0]   boot_count
);

  localparam int DEPTH = 1 << ADDR_W;
  // Internal word counter is wide enough to reach any 16-bit N, so loading
  // terminates even when the visible count has saturated.
  localparam int CNT_W = (ADDR_W + 1 > 16) ? ADDR_W + 1 : 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'({(ADDR_W+1){1'b1}});

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DAT_LO, DAT_HI, RUN} state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [7:0]        lo_reg, lo_next;
  logic [CNT_W-1:0]  words_reg, words_next;
  logic [CNT_W-1:0]  words_inc;
  logic              boot_hs;
  logic              boot_we;
  logic              run;

  logic [15:0]       mem [0:DEPTH-1];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  assign run        = (state_reg == RUN);
  assign boot_ready = !run;
  assign ready      = run;
  assign boot_hs    = boot_valid && !run;
  assign words_inc  = words_reg + CNT_W'(1);
  assign boot_count = (words_reg > CNT_MAX) ? CNT_MAX[ADDR_W:0] : words_reg[ADDR_W:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LEN_LO;
      len_reg   <= '0;
      lo_reg    <= '0;
      words_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      lo_reg    <= lo_next;
      words_reg <= words_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    lo_next    = lo_reg;
    words_next = words_reg;
    boot_we    = 1'b0;
    case (state_reg)
      LEN_LO: if (boot_hs) begin
        len_next[7:0] = boot_byte;
        state_next    = LEN_HI;
      end
      LEN_HI: if (boot_hs) begin
        len_next[15:8] = boot_byte;
        state_next     = ({boot_byte, len_reg[7:0]} == 16'd0) ? RUN : DAT_LO;
      end
      DAT_LO: if (boot_hs) begin
        lo_next    = boot_byte;
        state_next = DAT_HI;
      end
      DAT_HI: if (boot_hs) begin
        boot_we    = 1'b1;
        words_next = words_inc;
        state_next = (words_inc == CNT_W'(len_reg)) ? RUN : DAT_LO;
      end
      RUN:     state_next = RUN;
      default: state_next = LEN_LO;
    endcase
  end

  // Loader and CPU writes share one port; they are mutually exclusive by state.
  assign mem_we    = boot_we || (run && wen);
  assign mem_waddr = boot_we ? words_reg[ADDR_W-1:0] : waddr;
  assign mem_wdata = boot_we ? {boot_byte, lo_reg} : wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [ADDR_W-1:0] port_addr [2];
  assign port_addr[0] = raddr0;
  assign port_addr[1] = raddr1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [15:0] port_rdata_reg;
      logic [15:0] port_rdata_next;
`ifdef MEM_BYPASS_EN
      assign port_rdata_next = (wen && (port_addr[gi] == waddr)) ? wdata : mem[port_addr[gi]];
`else
      assign port_rdata_next = mem[port_addr[gi]];
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      port_rdata_reg <= '0;
        else if (run) port_rdata_reg <= port_rdata_next;
        else          port_rdata_reg <= '0;
      end
    end
  endgenerate

  assign rdata0 = g_rd[0].port_rdata_reg;
  assign rdata1 = g_rd[1].port_rdata_reg;

endmodule

// File: tb/tb_mem_boot_responder.sv
// Bench for mem_boot_responder: table-driven boot load, hand corner sequences, randomized traffic vs. a word-array model.
module tb_mem_boot_responder;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << (AW + 1)) - 1;

  logic          clk = 0;
  logic          rst = 0;
  logic [AW-1:0] raddr0 = 0, raddr1 = 0, waddr = 0;
  logic [15:0]   rdata0, rdata1, wdata = 0;
  logic          wen = 0, boot_valid = 0;
  logic [7:0]    boot_byte = 0;
  logic          boot_ready, ready;
  logic [AW:0]   boot_count;

  mem_boot_responder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .boot_valid(boot_valid), .boot_byte(boot_byte),
    .boot_ready(boot_ready), .ready(ready), .boot_count(boot_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: image described by stream position, not by loader states.
  logic [15:0] m_mem [DEPTH];
  bit          m_run;
  int          m_bytes, m_n, m_words;
  logic [7:0]  m_lo;
  bit          m_acc;
  logic [15:0] e_rd0, e_rd1;

`ifdef MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [AW-1:0] a);
    if (BYP && wen && a == waddr) return wdata;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    m_run = 0; m_bytes = 0; m_n = 0; m_words = 0; e_rd0 = 0; e_rd1 = 0;
  endtask

  task automatic model_edge();
    e_rd0 = m_run ? model_read(raddr0) : 16'h0;
    e_rd1 = m_run ? model_read(raddr1) : 16'h0;
    m_acc = boot_valid && !m_run;
    if (m_run && wen) m_mem[waddr] = wdata;
    if (m_acc) begin
      if (m_bytes == 0) m_n = int'(boot_byte);
      else if (m_bytes == 1) begin
        m_n = m_n + int'(boot_byte) * 256;
        if (m_n == 0) m_run = 1;
      end else if ((m_bytes % 2) == 0) m_lo = boot_byte;
      else begin
        m_mem[m_words % DEPTH] = {boot_byte, m_lo};
        m_words++;
        if (m_words == m_n) m_run = 1;
      end
      m_bytes++;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    cyc++;
    chk("rdata0", 32'(rdata0), 32'(e_rd0));
    chk("rdata1", 32'(rdata1), 32'(e_rd1));
    chk("ready", 32'(ready), 32'(m_run));
    chk("boot_ready", 32'(boot_ready), 32'(!m_run));
    chk("boot_count", 32'(boot_count), 32'((m_words > CMAX) ? CMAX : m_words));
    $display("cyc %0d bv=%b bb=%h wen=%b wa=%h wd=%h ra0=%h ra1=%h | rd0=%h rd1=%h rdy=%b brdy=%b cnt=%0d",
             cyc, boot_valid, boot_byte, wen, waddr, wdata, raddr0, raddr1,
             rdata0, rdata1, ready, boot_ready, boot_count);
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_boot_ready", 32'(boot_ready), 1);
    chk("rst_boot_count", 32'(boot_count), 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] b;
    logic       exp_ready;
    int         exp_cnt;
  } boot_vec_t;

  boot_vec_t tbl [8];
  logic [7:0] stream [$];
  logic [15:0] last_word;
  int idx, budget;

  initial begin
    tbl[0] = '{8'h03, 1'b0, 0}; tbl[1] = '{8'h00, 1'b0, 0};
    tbl[2] = '{8'h34, 1'b0, 0}; tbl[3] = '{8'h12, 1'b0, 1};
    tbl[4] = '{8'h78, 1'b0, 1}; tbl[5] = '{8'h56, 1'b0, 2};
    tbl[6] = '{8'hBC, 1'b0, 2}; tbl[7] = '{8'h9A, 1'b1, 3};

    model_reset();
    #1;
    do_reset();

    // Boot load with a CPU write held (and ignored) throughout loading.
    wen = 1; waddr = 1; wdata = 16'hFFFF; raddr0 = 0; raddr1 = 1;
    for (int i = 0; i < 8; i++) begin
      boot_valid = 1; boot_byte = tbl[i].b;
      if (i == 7) wen = 1; // still pre-RUN when this edge samples wen
      step();
      chk("tbl_ready", 32'(ready), 32'(tbl[i].exp_ready));
      chk("tbl_count", 32'(boot_count), 32'(tbl[i].exp_cnt));
      chk("tbl_rdata0_gated", 32'(rdata0), 0);
    end
    boot_valid = 0; wen = 0;
    raddr0 = 0; raddr1 = 1; step();
    chk("load_w0", 32'(rdata0), 32'h1234);
    chk("load_w1_not_overwritten", 32'(rdata1), 32'h5678);
    raddr0 = 2; raddr1 = 2; step();
    chk("dual_same_p0", 32'(rdata0), 32'h9ABC);
    chk("dual_same_p1", 32'(rdata1), 32'h9ABC);
    raddr0 = 1; raddr1 = 0; step();
    chk("dual_diff_p0", 32'(rdata0), 32'h5678);
    chk("dual_diff_p1", 32'(rdata1), 32'h1234);

    // Same-address read during write.
    wen = 1; waddr = 6'h10; wdata = 16'h1111; step();
    wdata = 16'h2222; raddr1 = 6'h10; step();
    chk("rw_same_edge", 32'(rdata1), BYP ? 32'h2222 : 32'h1111);
    wen = 0; step();
    chk("rw_next_read", 32'(rdata1), 32'h2222);

    // Empty image, then boot_valid must be ignored.
    do_reset();
    boot_valid = 1; boot_byte = 8'h00; step();
    chk("empty_ready_early", 32'(ready), 0);
    step();
    chk("empty_ready", 32'(ready), 1);
    chk("empty_count", 32'(boot_count), 0);
    chk("empty_boot_ready", 32'(boot_ready), 0);
    for (int i = 0; i < 3; i++) begin
      boot_byte = 8'(8'h55 + i); step();
    end
    chk("empty_count_hold", 32'(boot_count), 0);
    boot_valid = 0;

    // Reset mid-load after four bytes.
    do_reset();
    stream = '{8'h05, 8'h00, 8'hAA, 8'hBB};
    foreach (stream[i]) begin boot_valid = 1; boot_byte = stream[i]; step(); end
    chk("mid_count", 32'(boot_count), 1);
    boot_valid = 0;
    do_reset();
    chk("mid_after_ready", 32'(ready), 0);

    // Reload with N = DEPTH+1 and random valid gaps; final word wraps to address 0.
    stream.delete();
    stream.push_back(8'((DEPTH + 1) & 255));
    stream.push_back(8'((DEPTH + 1) >> 8));
    for (int k = 0; k <= DEPTH; k++) begin
      last_word = 16'($urandom);
      stream.push_back(last_word[7:0]);
      stream.push_back(last_word[15:8]);
    end
    idx = 0; budget = 2000;
    while (!m_run && budget > 0) begin
      boot_valid = ($urandom_range(0, 3) != 0);
      boot_byte  = stream[idx];
      step();
      if (m_acc) idx++;
      budget--;
    end
    chk("wrap_budget", 32'(budget > 0), 1);
    chk("wrap_ready", 32'(ready), 1);
    chk("wrap_count", 32'(boot_count), DEPTH + 1);
    boot_valid = 0; raddr0 = 0; raddr1 = 1; step();
    chk("wrap_addr0_last", 32'(rdata0), 32'(last_word));

    // Randomized CPU traffic in RUN, biased towards address collisions.
    for (int i = 0; i < 200; i++) begin
      boot_valid = 1'($urandom);
      boot_byte  = 8'($urandom);
      wen    = 1'($urandom);
      waddr  = 6'($urandom_range(0, 7));
      wdata  = 16'($urandom);
      raddr0 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      raddr1 = ($urandom_range(0, 1) != 0) ? waddr : 6'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
